// File: rtl/mvm_rect_pipe.sv
// mvm_rect_pipe: y = A*x for an M x N signed matrix using P parallel MAC lanes.
// Valid/ready output handshake, saturating or wrapping result, and retained
// A/x so several vectors can be run against one loaded matrix.
module mvm_rect_pipe #(
  parameter int M   = 16,
  parameter int N   = 12,
  parameter int B   = 8,
  parameter int P   = 4,
  parameter int SAT = 1
) (
  input  logic           clk,
  input  logic           reset,
  input  logic           loadMatrix,
  input  logic           loadVector,
  input  logic           start,
  input  logic           in_valid,
  input  logic [B-1:0]   data_in,
  output logic           busy,
  output logic           out_valid,
  input  logic           out_ready,
  output logic [2*B-1:0] data_out,
  output logic           done
);

  localparam int R  = M / P;
  localparam int K  = R * N;
  localparam int W  = 2 * B + $clog2(N);
  localparam int LW = (P > 1) ? $clog2(P) : 1;
  localparam int KW = (K > 1) ? $clog2(K) : 1;
  localparam int CW = (N > 1) ? $clog2(N) : 1;
  localparam int JW = (R > 1) ? $clog2(R) : 1;

  typedef enum logic [2:0] {
    IDLE,
    LOAD_M,
    LOAD_V,
    COMPUTE,
    DRAIN
  } state_t;

  state_t state;
  logic   mat_ok;
  logic   vec_ok;

  // load counters: rows are stored lane-major, so a flat local address per lane
  // walks rows lane*R .. lane*R+R-1 in row-major order
  logic [LW-1:0] ld_lane;
  logic [KW-1:0] ld_addr;
  logic [CW-1:0] ld_col;

  // issue counters for the compute sweep
  logic          iss_act;
  logic [KW-1:0] is_k;
  logic [CW-1:0] is_c;
  logic [JW-1:0] is_j;

  // pipeline stage metadata: address, read, product
  logic          a_v, r_v, p_v;
  logic [KW-1:0] a_k;
  logic [CW-1:0] a_c;
  logic [JW-1:0] a_j, r_j, p_j;
  logic          a_last, r_last, p_last;
  logic          fin;

  // drain position
  logic [LW-1:0] o_lane;
  logic [JW-1:0] o_j;

  // storage and datapath
  logic signed [B-1:0]   amem [P][K];
  logic signed [B-1:0]   xmem [N];
  logic signed [B-1:0]   a_rd [P];
  logic signed [B-1:0]   x_rd;
  logic signed [2*B-1:0] prod [P];
  logic signed [W-1:0]   acc  [P];
  logic signed [W-1:0]   sum  [P];
  logic [2*B-1:0]        rbuf [P][R];

  // reduce the full-width row sum to 2B bits, clamping or wrapping
  function automatic logic [2*B-1:0] reduce(input logic signed [W-1:0] v);
    logic signed [W-1:0] hi;
    logic signed [W-1:0] lo;
    hi = '0;
    hi[2*B-2:0] = '1;
    lo = '1;
    lo[2*B-2:0] = '0;
    if (SAT != 0 && v > hi)
      return hi[2*B-1:0];
    else if (SAT != 0 && v < lo)
      return lo[2*B-1:0];
    else
      return v[2*B-1:0];
  endfunction

  // control FSM: command decode, load counting, compute issue, drain handshake
  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      busy      <= 1'b0;
      out_valid <= 1'b0;
      data_out  <= '0;
      done      <= 1'b0;
      mat_ok    <= 1'b0;
      vec_ok    <= 1'b0;
      ld_lane   <= '0;
      ld_addr   <= '0;
      ld_col    <= '0;
      iss_act   <= 1'b0;
      is_k      <= '0;
      is_c      <= '0;
      is_j      <= '0;
      a_v       <= 1'b0;
      a_k       <= '0;
      a_c       <= '0;
      a_j       <= '0;
      a_last    <= 1'b0;
      r_v       <= 1'b0;
      r_j       <= '0;
      r_last    <= 1'b0;
      p_v       <= 1'b0;
      p_j       <= '0;
      p_last    <= 1'b0;
      fin       <= 1'b0;
      o_lane    <= '0;
      o_j       <= '0;
    end else begin
      done   <= 1'b0;
      a_v    <= 1'b0;
      r_v    <= a_v;
      r_j    <= a_j;
      r_last <= a_last;
      p_v    <= r_v;
      p_j    <= r_j;
      p_last <= r_last;
      case (state)
        IDLE: begin
          if (loadMatrix) begin
            state   <= LOAD_M;
            busy    <= 1'b1;
            mat_ok  <= 1'b0;
            ld_lane <= '0;
            ld_addr <= '0;
          end else if (loadVector) begin
            state  <= LOAD_V;
            busy   <= 1'b1;
            vec_ok <= 1'b0;
            ld_col <= '0;
          end else if (start && mat_ok && vec_ok) begin
            state   <= COMPUTE;
            busy    <= 1'b1;
            iss_act <= 1'b1;
            is_k    <= '0;
            is_c    <= '0;
            is_j    <= '0;
            fin     <= 1'b0;
          end
        end
        LOAD_M: begin
          if (in_valid) begin
            if (ld_addr == KW'(K - 1)) begin
              ld_addr <= '0;
              if (ld_lane == LW'(P - 1)) begin
                mat_ok <= 1'b1;
                busy   <= 1'b0;
                state  <= IDLE;
              end else begin
                ld_lane <= ld_lane + LW'(1);
              end
            end else begin
              ld_addr <= ld_addr + KW'(1);
            end
          end
        end
        LOAD_V: begin
          if (in_valid) begin
            if (ld_col == CW'(N - 1)) begin
              vec_ok <= 1'b1;
              busy   <= 1'b0;
              state  <= IDLE;
            end else begin
              ld_col <= ld_col + CW'(1);
            end
          end
        end
        COMPUTE: begin
          if (iss_act) begin
            a_v    <= 1'b1;
            a_k    <= is_k;
            a_c    <= is_c;
            a_j    <= is_j;
            a_last <= (is_c == CW'(N - 1));
            if (is_k == KW'(K - 1))
              iss_act <= 1'b0;
            is_k <= is_k + KW'(1);
            if (is_c == CW'(N - 1)) begin
              is_c <= '0;
              is_j <= is_j + JW'(1);
            end else begin
              is_c <= is_c + CW'(1);
            end
          end
          // last row of every lane is written on this edge; drain starts next
          if (p_v && p_last && p_j == JW'(R - 1))
            fin <= 1'b1;
          if (fin) begin
            fin       <= 1'b0;
            state     <= DRAIN;
            out_valid <= 1'b1;
            data_out  <= rbuf[0][0];
            o_lane    <= '0;
            o_j       <= '0;
          end
        end
        DRAIN: begin
          if (out_valid && out_ready) begin
            if (o_lane == LW'(P - 1) && o_j == JW'(R - 1)) begin
              out_valid <= 1'b0;
              done      <= 1'b1;
              busy      <= 1'b0;
              state     <= IDLE;
            end else if (o_j == JW'(R - 1)) begin
              o_j      <= '0;
              o_lane   <= o_lane + LW'(1);
              data_out <= rbuf[o_lane + LW'(1)][0];
            end else begin
              o_j      <= o_j + JW'(1);
              data_out <= rbuf[o_lane][o_j + JW'(1)];
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // matrix and vector storage writes; contents survive reset
  always_ff @(posedge clk) begin
    if (!reset && state == LOAD_M && in_valid)
      amem[ld_lane][ld_addr] <= data_in;
    if (!reset && state == LOAD_V && in_valid)
      xmem[ld_col] <= data_in;
  end

  // read register and product register for every lane
  always_ff @(posedge clk) begin
    x_rd <= xmem[a_c];
    for (int unsigned l = 0; l < P; l++) begin
      a_rd[l] <= amem[l][a_k];
      prod[l] <= (2*B)'(a_rd[l]) * (2*B)'(x_rd);
    end
  end

  // running row sum including the product arriving this cycle
  always_comb begin
    for (int unsigned l = 0; l < P; l++)
      sum[l] = acc[l] + W'(prod[l]);
  end

  // accumulate; at a row end the accumulator clears in the same cycle
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int unsigned l = 0; l < P; l++)
        acc[l] <= '0;
    end else if (p_v) begin
      for (int unsigned l = 0; l < P; l++)
        acc[l] <= p_last ? '0 : sum[l];
    end
  end

  // result buffer write at each row end
  always_ff @(posedge clk) begin
    if (!reset && p_v && p_last) begin
      for (int unsigned l = 0; l < P; l++)
        rbuf[l][p_j] <= reduce(sum[l]);
    end
  end

endmodule

// File: tb/tb_mvm_rect_pipe.sv
// Bench for mvm_rect_pipe: two instances (saturating and wrapping) share stimulus;
// expected rows are queued at start and popped as beats transfer.
module tb_mvm_rect_pipe;

  localparam int M = 4;
  localparam int N = 3;
  localparam int B = 8;
  localparam int P = 2;

  logic clk = 1'b0;
  logic reset, loadMatrix, loadVector, start, in_valid, out_ready;
  logic [B-1:0] data_in;
  logic busy_s, ov_s, done_s, busy_w, ov_w, done_w;
  logic [2*B-1:0] do_s, do_w;

  always #5 clk = ~clk;

  mvm_rect_pipe #(.M(M), .N(N), .B(B), .P(P), .SAT(1)) u_sat (
    .clk(clk), .reset(reset), .loadMatrix(loadMatrix), .loadVector(loadVector),
    .start(start), .in_valid(in_valid), .data_in(data_in), .busy(busy_s),
    .out_valid(ov_s), .out_ready(out_ready), .data_out(do_s), .done(done_s));

  mvm_rect_pipe #(.M(M), .N(N), .B(B), .P(P), .SAT(0)) u_wrap (
    .clk(clk), .reset(reset), .loadMatrix(loadMatrix), .loadVector(loadVector),
    .start(start), .in_valid(in_valid), .data_in(data_in), .busy(busy_w),
    .out_valid(ov_w), .out_ready(out_ready), .data_out(do_w), .done(done_w));

  int passed = 0;
  int total = 0;
  int q_sat[$];
  int q_wrap[$];
  int xfers = 0;
  int done_cnt = 0;

  typedef struct {
    bit load_m;
    int a[12];
    int x[3];
    int ys[4];
    int yw[4];
  } vec_t;

  vec_t vt[5];

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act == exp) passed++;
    else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // scoreboard: compare each transferring beat against the queued expectation
  always @(negedge clk) begin
    if (!reset) begin
      if (ov_s && out_ready) begin
        xfers++;
        if (q_sat.size() == 0) begin
          total++;
          $display("FAIL sat_extra: beat %0d with no expected entry", $signed(do_s));
        end else chk("sat_data", int'($signed(do_s)), q_sat.pop_front());
      end
      if (ov_w && out_ready) begin
        xfers++;
        if (q_wrap.size() == 0) begin
          total++;
          $display("FAIL wrap_extra: beat %0d with no expected entry", $signed(do_w));
        end else chk("wrap_data", int'($signed(do_w)), q_wrap.pop_front());
      end
      if (done_s) done_cnt++;
      if (done_w) done_cnt++;
    end
  end

  task automatic load_mat(input int a[12], input bit gaps);
    loadMatrix = 1'b1;
    in_valid = 1'b1;
    data_in = 8'h55;
    tick();
    loadMatrix = 1'b0;
    chk("busy_after_loadm", int'(busy_s), 1);
    for (int i = 0; i < 12; i++) begin
      if (gaps) begin
        in_valid = 1'b0;
        data_in = 8'h7f;
        tick();
      end
      in_valid = 1'b1;
      data_in = 8'(a[i]);
      tick();
    end
    in_valid = 1'b0;
    chk("busy_after_mat_load", int'(busy_s), 0);
  endtask

  task automatic load_vec(input int x[3]);
    loadVector = 1'b1;
    in_valid = 1'b1;
    data_in = 8'h33;
    tick();
    loadVector = 1'b0;
    for (int i = 0; i < 3; i++) begin
      in_valid = 1'b1;
      data_in = 8'(x[i]);
      tick();
    end
    in_valid = 1'b0;
    chk("busy_after_vec_load", int'(busy_s), 0);
  endtask

  task automatic run(input int ys[4], input int yw[4], input bit stall, input bit inject);
    int lat;
    int cyc;
    int x0;
    int d0;
    for (int k = 0; k < 4; k++) begin
      q_sat.push_back(ys[k]);
      q_wrap.push_back(yw[k]);
    end
    x0 = xfers;
    d0 = done_cnt;
    out_ready = 1'b1;
    start = 1'b1;
    tick();
    start = 1'b0;
    chk("busy_after_start", int'(busy_s), 1);
    lat = 0;
    while (!ov_s && lat < 60) begin
      if (inject && lat == 2) begin
        loadMatrix = 1'b1;
        in_valid = 1'b1;
        data_in = 8'h11;
      end
      tick();
      loadMatrix = 1'b0;
      in_valid = 1'b0;
      lat++;
    end
    chk("first_valid_latency", lat, 10);
    if (stall) begin
      tick();
      out_ready = 1'b0;
      for (int s = 0; s < 3; s++) begin
        chk("stall_valid", int'(ov_s), 1);
        chk("stall_hold", int'($signed(do_s)), 15);
        tick();
      end
      out_ready = 1'b1;
    end
    cyc = 0;
    while (!done_s && cyc < 60) begin
      tick();
      cyc++;
    end
    chk("done_seen", int'(done_s), 1);
    chk("drain_cycles", cyc, stall ? 3 : 4);
    chk("busy_at_done", int'(busy_s), 0);
    chk("valid_at_done", int'(ov_s), 0);
    chk("beats_transferred", xfers - x0, 8);
    chk("queue_empty", q_sat.size() + q_wrap.size(), 0);
    tick();
    chk("done_pulse_low", int'(done_s), 0);
    chk("done_count", done_cnt - d0, 2);
  endtask

  initial begin
    int seen;
    vt[0].load_m = 1'b1;
    vt[0].a  = '{1, 2, 3, 4, 5, 6, 7, 8, 9, -1, -2, -3};
    vt[0].x  = '{1, 1, 1};
    vt[0].ys = '{6, 15, 24, -6};
    vt[0].yw = '{6, 15, 24, -6};
    vt[1].load_m = 1'b0;
    vt[1].a  = vt[0].a;
    vt[1].x  = '{2, 0, -1};
    vt[1].ys = '{-1, 2, 5, 1};
    vt[1].yw = '{-1, 2, 5, 1};
    vt[2].load_m = 1'b1;
    vt[2].a  = '{-128, -128, -128, -128, -128, -128, -128, -128, -128, -128, -128, -128};
    vt[2].x  = '{-128, -128, -128};
    vt[2].ys = '{32767, 32767, 32767, 32767};
    vt[2].yw = '{-16384, -16384, -16384, -16384};
    vt[3].load_m = 1'b0;
    vt[3].a  = vt[2].a;
    vt[3].x  = '{127, 127, 127};
    vt[3].ys = '{-32768, -32768, -32768, -32768};
    vt[3].yw = '{16768, 16768, 16768, 16768};
    vt[4].load_m = 1'b1;
    vt[4].a  = '{127, -128, 5, 0, 0, 0, -1, -1, -1, 100, 100, 100};
    vt[4].x  = '{127, 127, -128};
    vt[4].ys = '{-767, 0, -126, 12600};
    vt[4].yw = '{-767, 0, -126, 12600};

    reset = 1'b1;
    loadMatrix = 1'b0;
    loadVector = 1'b0;
    start = 1'b0;
    in_valid = 1'b0;
    data_in = '0;
    out_ready = 1'b1;
    repeat (3) tick();
    chk("rst_busy", int'(busy_s), 0);
    chk("rst_out_valid", int'(ov_s), 0);
    chk("rst_data_out", int'(do_s), 0);
    chk("rst_done", int'(done_s), 0);
    chk("rst_wrap_valid", int'(ov_w), 0);
    reset = 1'b0;
    tick();

    // start with nothing loaded, then with only the matrix loaded
    start = 1'b1;
    tick();
    start = 1'b0;
    chk("guard_empty_busy", int'(busy_s), 0);
    load_mat(vt[0].a, 1'b0);
    start = 1'b1;
    tick();
    start = 1'b0;
    chk("guard_novec_busy", int'(busy_s), 0);
    seen = 0;
    for (int i = 0; i < 15; i++) begin
      if (ov_s || ov_w || busy_s) seen++;
      tick();
    end
    chk("guard_no_output", seen, 0);

    for (int i = 0; i < 5; i++) begin
      if (vt[i].load_m) load_mat(vt[i].a, 1'b0);
      load_vec(vt[i].x);
      run(vt[i].ys, vt[i].yw, 1'b0, 1'b0);
    end

    // backpressure while 15 is presented
    load_mat(vt[0].a, 1'b0);
    load_vec(vt[0].x);
    run(vt[0].ys, vt[0].yw, 1'b1, 1'b0);

    // in_valid toggling during the matrix load, junk on idle beats
    load_mat(vt[0].a, 1'b1);
    load_vec(vt[1].x);
    run(vt[1].ys, vt[1].yw, 1'b0, 1'b0);

    // loadMatrix during COMPUTE is ignored, A remains intact afterwards
    run(vt[1].ys, vt[1].yw, 1'b0, 1'b1);
    run(vt[1].ys, vt[1].yw, 1'b0, 1'b0);

    // reset in the middle of COMPUTE
    start = 1'b1;
    tick();
    start = 1'b0;
    repeat (4) tick();
    reset = 1'b1;
    tick();
    chk("midrst_busy", int'(busy_s), 0);
    chk("midrst_valid", int'(ov_s), 0);
    chk("midrst_done", int'(done_s), 0);
    reset = 1'b0;
    tick();
    load_vec(vt[0].x);
    start = 1'b1;
    tick();
    start = 1'b0;
    chk("midrst_no_matrix_busy", int'(busy_s), 0);
    seen = 0;
    for (int i = 0; i < 15; i++) begin
      if (ov_s || busy_s) seen++;
      tick();
    end
    chk("midrst_no_output", seen, 0);
    load_mat(vt[0].a, 1'b0);
    run(vt[0].ys, vt[0].yw, 1'b0, 1'b0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/mvm_rect_pipe.md
# mvm_rect_pipe

Parametrised successor to the square single-vector matrix-vector multiplier. It computes y = A·x for a rectangular M×N signed matrix using P parallel MAC lanes. It adds valid/ready input and output handshakes, selectable saturating or wrapping output, and matrix retention so that several vectors can be multiplied against one loaded matrix. It sits between the stream loader and the result consumer, in the same slot as the current mvm top.

## Interface
- M, 16, matrix rows / output length; must be a multiple of P
- N, 12, matrix columns / vector length; N ≥ 1
- B, 8, input element width (signed)
- P, 4, parallel lanes; R = M/P rows per lane
- SAT, 1, 1 = saturate result to 2B bits, 0 = wrap (keep low 2B bits)
- clk  in  1  clock; all logic on posedge
- reset  in  1  synchronous, active-high
- loadMatrix  in  1  command pulse: load M·N elements, row-major
- loadVector  in  1  command pulse: load N elements
- start  in  1  command pulse: compute y with the stored A and x
- in_valid  in  1  data_in beat valid
- data_in  in  B  signed element
- busy  out  1  high in any state other than IDLE
- out_valid  out  1  data_out holds a result
- out_ready  in  1  consumer accepts data_out
- data_out  out  2B  signed y element
- done  out  1  one-cycle pulse after the last y element is accepted

## Operation
- Reset values: busy=0, out_valid=0, data_out=0, done=0, state=IDLE, mat_ok=0, vec_ok=0. Memory contents are not cleared.
- States: IDLE, LOAD_M, LOAD_V, COMPUTE, DRAIN.
- IDLE command priority: loadMatrix > loadVector > start.
  - A start with mat_ok=0 or vec_ok=0 is ignored.
  - Commands are ignored in every state except IDLE.
- LOAD_M:
  - Beats are counted only when in_valid=1, starting the cycle after the command. data_in in the command cycle is ignored.
  - Row r goes to lane r/R, local row r%R.
  - After beat M·N: mat_ok=1, return to IDLE.
  - mat_ok is cleared on entry to LOAD_M.
- LOAD_V: same rules with N beats; sets vec_ok. The vector is shared by all lanes. vec_ok is cleared on entry to LOAD_V.
- COMPUTE:
  - For j = 0..R-1 and c = 0..N-1, every lane l accumulates A[l·R+j][c]·x[c].
  - Products are full 2B-bit signed. The accumulator is W = 2B+clog2(N) bits signed, so it never overflows.
  - At the end of each row the accumulator clears with no bubble cycle. The result goes into an M-entry result buffer.
  - The result is reduced to 2B bits:
    - SAT=1: clamp to [−2^(2B−1), 2^(2B−1)−1].
    - SAT=0: keep bits [2B−1:0].
- DRAIN:
  - Emits y[0]..y[M−1] in order. A beat transfers when out_valid & out_ready.
  - data_out is stable while out_valid=1 and out_ready=0.
  - After the M-th transfer, the next cycle has out_valid=0, done=1, state=IDLE.
- A and x are retained after computation. A new vector alone followed by start reuses A.
- Reset at any point returns to IDLE in the following cycle with all flags and outputs at reset values. The interrupted result is discarded.

## Timing
- Let start be sampled at edge t.
- Pipeline: read addresses issued t+1..t+R·N, RAM read register, product register, accumulate/write to result buffer.
- First out_valid=1 in the cycle after edge t+R·N+4. This is exact and independent of out_ready.
- Drain with out_ready held at 1 takes M cycles. done is high the cycle after the last transfer.
- busy rises in the cycle after a command is accepted and falls in the same cycle done rises.
- Load latency: with in_valid held at 1, the load completes M·N (or N) cycles after the command. busy=0 the cycle after the final beat.

## Test plan
- M=4, N=3, P=2. A rows [1,2,3], [4,5,6], [7,8,9], [−1,−2,−3]; x=[1,1,1]; start; out_ready=1 → data_out 6, 15, 24, −6 in order. First out_valid exactly R·N+4 = 10 cycles after start. done a single pulse.
- B=8, N=3, all A=−128, x=−128 (sum 49152) → SAT=1: 32767 on every row. SAT=0: −16384 on every row.
- Case 1 with out_ready=0 for 3 cycles after the second beat → data_out holds 15. No element lost or duplicated. done only after −6 transfers.
- After case 1, loadVector x=[2,0,−1] only, then start → −1, 2, 5, 1.
- Guards:
  - After reset, start with no vector loaded → busy stays 0 and no output.
  - in_valid toggled 1/0 during LOAD_M → exactly 12 valid beats are stored.
  - loadMatrix issued during COMPUTE → ignored; results unchanged.
- Reset asserted mid-COMPUTE → next cycle busy=0, out_valid=0, done=0. A subsequent start is ignored until both A and x are reloaded.
